// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline.
// Holds the datapath widths, the NOP encoding, the default reset PC and
// the IF/ID pipeline-register record that the ID stage also consumes.
package mips_pkg;

    localparam int          ADDR_W   = 32;
    localparam int          INSTR_W  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
        logic               valid;
    } ifid_t;

    // Bubble value loaded on redirect or flush.
    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

endpackage

// File: rtl/if_stage_pc_ifid_if.sv
// Bus between the instruction-fetch stage and its surroundings
// (hazard unit, ID-stage redirect logic, instruction memory, decode).
//   master : the fetch stage (drives imem_addr, IF/ID outputs, fetch_count)
//   slave  : the environment (drives control, redirect and imem_rdata)
interface if_stage_pc_ifid_if
    import mips_pkg::*;
#(
    parameter int A_W = ADDR_W,
    parameter int I_W = INSTR_W
) ();

    logic           stall;
    logic           flush;
    logic           branch_taken;
    logic [A_W-1:0] branch_target;
    logic           jump;
    logic [25:0]    jump_index;
    logic [A_W-1:0] imem_addr;
    logic [I_W-1:0] imem_rdata;
    logic [I_W-1:0] if_id_instr;
    logic [A_W-1:0] if_id_pc_plus4;
    logic           if_id_valid;
    logic [31:0]    fetch_count;

    modport master (
        input  stall, flush, branch_taken, branch_target, jump, jump_index, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, jump, jump_index, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count
    );

endinterface

// File: rtl/en_reg_async.sv
// Width-parameterised register with enable and asynchronous active-high
// clear to a configurable value.
//   clk   : rising-edge clock
//   clear : asynchronous clear, loads CLEAR_VAL immediately
//   en    : load d on the rising edge when high, otherwise hold
//   d / q : data in / registered data out
module en_reg_async
    import mips_pkg::*;
#(
    parameter int               WIDTH     = ADDR_W,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q <= CLEAR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage_pc_ifid.sv
// Instruction-fetch stage: program counter, next-PC selection
// (sequential / branch / jump / stall) and the IF/ID pipeline register.
//   clk   : rising-edge pipeline clock
//   clear : asynchronous active-high reset of PC, IF/ID and fetch_count
//   bus   : master side of if_stage_pc_ifid_if
//           inputs  stall, flush, branch_taken, branch_target, jump,
//                   jump_index, imem_rdata
//           outputs imem_addr (= PC), if_id_instr, if_id_pc_plus4,
//                   if_id_valid, fetch_count
module if_stage_pc_ifid
    import mips_pkg::*;
#(
    parameter int               ADDR_W   = mips_pkg::ADDR_W,
    parameter int               INSTR_W  = mips_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               clear,
    if_stage_pc_ifid_if.master bus
);

    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              pc_en;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_aligned;
    logic              redirect;

    ifid_t             ifid_d, ifid_q;
    logic              bubble;
    logic              accept;
    logic              ifid_en;

    logic [31:0]       fetch_count_d, fetch_count_q;

    // ---------------- next-PC selection ----------------
    assign redirect       = bus.branch_taken | bus.jump;
    assign pc_plus4       = pc_q + ADDR_W'(4);
    // Jump region comes from the IF-stage PC+4, matching branch-in-ID timing.
    assign jump_target    = {pc_plus4[ADDR_W-1:28], bus.jump_index, 2'b00};
    assign branch_aligned = bus.branch_target & ~ADDR_W'(3);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pc_d = pc_plus4;
        if (bus.branch_taken) begin
            pc_d = branch_aligned;
        end else if (bus.jump) begin
            pc_d = jump_target;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end
    end

    // A redirect must never be swallowed by a stall.
    assign pc_en = ~bus.stall | redirect;

    en_reg_async #(.WIDTH(ADDR_W), .CLEAR_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .clear (clear),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    // ---------------- IF/ID register ----------------
    // flush with stall still squashes: that is the load-use bubble.
    assign bubble  = redirect | bus.flush;
    assign accept  = ~bubble & ~bus.stall;
    assign ifid_en = bubble | accept;

    always_comb begin
        ifid_d = IFID_BUBBLE;
        if (accept) begin
            ifid_d.instr    = bus.imem_rdata;
            ifid_d.pc_plus4 = pc_plus4;
            ifid_d.valid    = 1'b1;
        end
    end

    en_reg_async #(.WIDTH(INSTR_W), .CLEAR_VAL(NOP_INSTR)) u_instr_reg (
        .clk   (clk),
        .clear (clear),
        .en    (ifid_en),
        .d     (ifid_d.instr),
        .q     (ifid_q.instr)
    );

    en_reg_async #(.WIDTH(ADDR_W), .CLEAR_VAL('0)) u_pc_plus4_reg (
        .clk   (clk),
        .clear (clear),
        .en    (ifid_en),
        .d     (ifid_d.pc_plus4),
        .q     (ifid_q.pc_plus4)
    );

    en_reg_async #(.WIDTH(1), .CLEAR_VAL(1'b0)) u_valid_reg (
        .clk   (clk),
        .clear (clear),
        .en    (ifid_en),
        .d     (ifid_d.valid),
        .q     (ifid_q.valid)
    );

    // ---------------- fetch counter ----------------
    // Saturates instead of wrapping.
    assign fetch_count_d = (fetch_count_q == '1) ? fetch_count_q : fetch_count_q + 32'd1;

    en_reg_async #(.WIDTH(32), .CLEAR_VAL('0)) u_fetch_count_reg (
        .clk   (clk),
        .clear (clear),
        .en    (accept),
        .d     (fetch_count_d),
        .q     (fetch_count_q)
    );

    // ---------------- outputs ----------------
    assign bus.imem_addr      = pc_q;
    assign bus.if_id_instr    = ifid_q.instr;
    assign bus.if_id_pc_plus4 = ifid_q.pc_plus4;
    assign bus.if_id_valid    = ifid_q.valid;
    assign bus.fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_if_stage_pc_ifid.sv
// Self-checking bench for if_stage_pc_ifid. Instruction memory is modelled
// as rdata = 32'h2000_0000 + address. A stimulus table drives one edge per
// row; each row's expected outputs go into a scoreboard queue when the row
// is driven and are popped and compared after the edge.
module tb_if_stage_pc_ifid;

    logic clk   = 1'b0;
    logic clear = 1'b1;

    always #5 clk = ~clk;

    if_stage_pc_ifid_if bus ();

    if_stage_pc_ifid #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.master)
    );

    assign bus.imem_rdata = 32'h2000_0000 + bus.imem_addr;

    typedef struct {
        logic        rst_before;
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] br_tgt;
        logic        jmp;
        logic [25:0] jidx;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs[23];
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic rb, input logic st, input logic fl,
                           input logic br, input logic [31:0] bt, input logic jp,
                           input logic [25:0] ji, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input logic v, input logic [31:0] c);
        vecs[i] = '{rb, st, fl, br, bt, jp, ji, pc, ins, p4, v, c};
    endtask

    task automatic drive_idle();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_index    = '0;
    endtask

    // Called at a negedge: apply one row, push its expectation, clock once,
    // then pop and compare at the following negedge.
    task automatic apply(input int i);
        exp_t e;
        if (vecs[i].rst_before) begin
            clear = 1'b1;
            #1;
            clear = 1'b0;
        end
        bus.stall         = vecs[i].stall;
        bus.flush         = vecs[i].flush;
        bus.branch_taken  = vecs[i].br;
        bus.branch_target = vecs[i].br_tgt;
        bus.jump          = vecs[i].jmp;
        bus.jump_index    = vecs[i].jidx;
        sb.push_back('{i, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                       vecs[i].e_valid, vecs[i].e_cnt});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check($sformatf("v%0d pc", e.idx),    bus.imem_addr,      e.pc);
        check($sformatf("v%0d instr", e.idx), bus.if_id_instr,    e.instr);
        check($sformatf("v%0d pc4", e.idx),   bus.if_id_pc_plus4, e.pc4);
        check($sformatf("v%0d valid", e.idx), 32'(bus.if_id_valid), 32'(e.valid));
        check($sformatf("v%0d cnt", e.idx),   bus.fetch_count,    e.cnt);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        //          rb st fl br target        jp jidx      pc            instr         pc4           v  cnt
        set_vec( 0, 1, 0, 0, 0, 32'h0,        0, 26'h0,  32'h4,        32'h2000_0000, 32'h4,        1, 1);
        set_vec( 1, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h8,        32'h2000_0004, 32'h8,        1, 2);
        set_vec( 2, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'hC,        32'h2000_0008, 32'hC,        1, 3);
        set_vec( 3, 1, 0, 0, 0, 32'h0,        0, 26'h0,  32'h4,        32'h2000_0000, 32'h4,        1, 1);
        set_vec( 4, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h8,        32'h2000_0004, 32'h8,        1, 2);
        set_vec( 5, 0, 1, 0, 0, 32'h0,        0, 26'h0,  32'h8,        32'h2000_0004, 32'h8,        1, 2);
        set_vec( 6, 0, 1, 0, 0, 32'h0,        0, 26'h0,  32'h8,        32'h2000_0004, 32'h8,        1, 2);
        set_vec( 7, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'hC,        32'h2000_0008, 32'hC,        1, 3);
        set_vec( 8, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h10,       32'h2000_000C, 32'h10,       1, 4);
        set_vec( 9, 0, 0, 0, 1, 32'h103,      0, 26'h0,  32'h100,      32'h0,         32'h0,        0, 4);
        set_vec(10, 0, 1, 0, 1, 32'h103,      0, 26'h0,  32'h100,      32'h0,         32'h0,        0, 4);
        set_vec(11, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h104,      32'h2000_0100, 32'h104,      1, 5);
        set_vec(12, 0, 0, 0, 1, 32'h1000_0000,0, 26'h0,  32'h1000_0000,32'h0,         32'h0,        0, 5);
        set_vec(13, 0, 0, 0, 0, 32'h0,        1, 26'h40, 32'h1000_0100,32'h0,         32'h0,        0, 5);
        set_vec(14, 0, 0, 0, 1, 32'h1000_0000,0, 26'h0,  32'h1000_0000,32'h0,         32'h0,        0, 5);
        set_vec(15, 0, 0, 0, 1, 32'h200,      1, 26'h40, 32'h200,      32'h0,         32'h0,        0, 5);
        set_vec(16, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h204,      32'h2000_0200, 32'h204,      1, 6);
        set_vec(17, 0, 1, 1, 0, 32'h0,        0, 26'h0,  32'h204,      32'h0,         32'h0,        0, 6);
        set_vec(18, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h208,      32'h2000_0204, 32'h208,      1, 7);
        set_vec(19, 0, 0, 1, 0, 32'h0,        0, 26'h0,  32'h20C,      32'h0,         32'h0,        0, 7);
        set_vec(20, 0, 0, 0, 1, 32'hFFFF_FFFF,0, 26'h0,  32'hFFFF_FFFC,32'h0,         32'h0,        0, 7);
        set_vec(21, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h0,        32'h1FFF_FFFC, 32'h0,        1, 8);
        set_vec(22, 0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h4,        32'h2000_0000, 32'h4,        1, 9);

        drive_idle();
        clear = 1'b1;
        #2;
        check("reset pc",    bus.imem_addr,            32'h0);
        check("reset instr", bus.if_id_instr,          32'h0);
        check("reset pc4",   bus.if_id_pc_plus4,       32'h0);
        check("reset valid", 32'(bus.if_id_valid),     32'h0);
        check("reset cnt",   bus.fetch_count,          32'h0);

        @(negedge clk);
        clear = 1'b0;

        for (int i = 0; i < 23; i++) begin
            apply(i);
        end
        drive_idle();

        // Async clear between edges: state must drop before any clock edge.
        #2;
        clear = 1'b1;
        #1;
        check("async pc",    bus.imem_addr,        32'h0);
        check("async valid", 32'(bus.if_id_valid), 32'h0);
        check("async instr", bus.if_id_instr,      32'h0);
        check("async cnt",   bus.fetch_count,      32'h0);
        @(negedge clk);
        clear = 1'b0;

        // First edge after release fetches from RESET_PC.
        @(posedge clk);
        @(negedge clk);
        check("post-reset instr", bus.if_id_instr,   32'h2000_0000);
        check("post-reset pc",    bus.imem_addr,     32'h4);
        check("post-reset cnt",   bus.fetch_count,   32'h1);

        check("scoreboard empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
